// File: rtl/video_timing_generator_pkg.sv
// Shared widths, timing presets and per-axis decode types.
// Imported by the axis counter, the interface users and the top.
package video_timing_generator_pkg;

  function automatic int cw(input int n);
    return $clog2(n) + 1;
  endfunction

  localparam bit POL_POS = 1'b1;
  localparam bit POL_NEG = 1'b0;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_TOTAL  = 800;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_TOTAL  = 525;

  localparam int HD_H_ACTIVE = 1280;
  localparam int HD_H_FP     = 110;
  localparam int HD_H_SYNC   = 40;
  localparam int HD_H_TOTAL  = 1650;
  localparam int HD_V_ACTIVE = 720;
  localparam int HD_V_FP     = 5;
  localparam int HD_V_SYNC   = 5;
  localparam int HD_V_TOTAL  = 750;

  typedef enum logic [1:0] {
    RG_ACTIVE,
    RG_PORCH,
    RG_SYNC,
    RG_BACK
  } region_e;

  typedef struct packed {
    logic wrap;
    logic active;
    logic sync;
    logic mark;
  } axis_t;

endpackage

// File: rtl/video_timing_generator_if.sv
// Raster timing bundle driven by the generator.
// Widths follow cw() of the divider and the line/frame totals.
interface video_timing_generator_if #(
  parameter int SW = 2,
  parameter int HW = 6,
  parameter int VW = 6
);
  logic          oPixelCe;
  logic [SW-1:0] oSub;
  logic [HW-1:0] oHpixel;
  logic [VW-1:0] oVpixel;
  logic          oHsync;
  logic          oVsync;
  logic          oActive;
  logic          oLineStart;
  logic          oFrameSync;
  logic          oLocked;

  modport master (
    output oPixelCe, oSub, oHpixel, oVpixel,
    output oHsync, oVsync, oActive,
    output oLineStart, oFrameSync, oLocked
  );

  modport slave (
    input oPixelCe, oSub, oHpixel, oVpixel,
    input oHsync, oVsync, oActive,
    input oLineStart, oFrameSync, oLocked
  );
endinterface

// File: rtl/video_timing_axis.sv
// One raster axis: wrapping position counter plus
// active/porch/sync region decode and a single-position mark.
module video_timing_axis
  import video_timing_generator_pkg::*;
#(
  parameter int TOTAL  = 32,
  parameter int ACTIVE = 24,
  parameter int FP     = 2,
  parameter int SYNC   = 4,
  parameter int MARK   = 0,
  parameter int W      = 6
) (
  input  logic         iClk,
  input  logic         iRstN,
  input  logic         iClr,
  input  logic         iEn,
  output logic [W-1:0] oPos,
  output axis_t        oDec
);
  localparam logic [W-1:0] LAST = W'(TOTAL - 1);
  localparam logic [W-1:0] FP_START = W'(ACTIVE);
  localparam logic [W-1:0] SY_START = W'(ACTIVE + FP);
  localparam logic [W-1:0] SY_END = W'(ACTIVE + FP + SYNC);
  localparam logic [W-1:0] MARK_POS = W'(MARK % TOTAL);

  logic [W-1:0] pos;
  region_e      region;

  // position counter; clear wins over the natural advance
  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      pos <= '0;
    end else if (iClr) begin
      pos <= '0;
    end else if (iEn) begin
      pos <= (pos == LAST) ? '0 : pos + 1'b1;
    end
  end

  // classify the current position into its raster region
  always_comb begin
    region = RG_BACK;
    unique case (1'b1)
      (pos < FP_START):
        region = RG_ACTIVE;
      (pos >= FP_START && pos < SY_START):
        region = RG_PORCH;
      (pos >= SY_START && pos < SY_END):
        region = RG_SYNC;
      default:
        region = RG_BACK;
    endcase
  end

  assign oPos = pos;
  assign oDec.wrap = (pos == LAST);
  assign oDec.active = (region == RG_ACTIVE);
  assign oDec.sync = (region == RG_SYNC);
  assign oDec.mark = (pos == MARK_POS);

endmodule

// File: rtl/video_timing_generator.sv
// Raster timing top: pixel divider, H/V axes, resync, frame strobe.
// Optional lock detector enabled by VIDEO_TIMING_LOCK_DETECT_EN.
module video_timing_generator
  import video_timing_generator_pkg::*;
#(
  parameter int PIXEL_DIV      = 2,
  parameter int H_ACTIVE       = 24,
  parameter int H_FP           = 2,
  parameter int H_SYNC         = 4,
  parameter int H_TOTAL        = 32,
  parameter int V_ACTIVE       = 16,
  parameter int V_FP           = 1,
  parameter int V_SYNC         = 2,
  parameter int V_TOTAL        = 24,
  parameter bit HS_POL         = 1'b1,
  parameter bit VS_POL         = 1'b1,
  parameter int SYNC_DELAY_SUB = 0,
  parameter int SYNC_DELAY_H   = 0,
  parameter int SYNC_DELAY_V   = 0,
  parameter int LOCK_COUNT     = 4
) (
  input logic iClk,
  input logic iRstN,
  input logic iResync,
  video_timing_generator_if.master vid
);
  localparam int SW = cw(PIXEL_DIV);
  localparam int HW = cw(H_TOTAL);
  localparam int VW = cw(V_TOTAL);
  localparam logic [SW-1:0] SUB_LAST = SW'(PIXEL_DIV - 1);
  localparam logic [SW-1:0] SUB_MARK = SW'(SYNC_DELAY_SUB);

  if (PIXEL_DIV < 1) begin : gBadDiv
    $fatal(1, "PIXEL_DIV must be at least 1");
  end
  if (H_ACTIVE + H_FP + H_SYNC > H_TOTAL) begin : gBadH
    $fatal(1, "horizontal active+porch+sync exceeds H_TOTAL");
  end
  if (V_ACTIVE + V_FP + V_SYNC > V_TOTAL) begin : gBadV
    $fatal(1, "vertical active+porch+sync exceeds V_TOTAL");
  end
  if (SYNC_DELAY_SUB >= PIXEL_DIV) begin : gBadSub
    $fatal(1, "SYNC_DELAY_SUB must be below PIXEL_DIV");
  end
  if (LOCK_COUNT < 1) begin : gBadLock
    $fatal(1, "LOCK_COUNT must be at least 1");
  end

  logic [SW-1:0] sub;
  logic          subWrap;
  logic [HW-1:0] hPos;
  logic [VW-1:0] vPos;
  axis_t         hDec;
  axis_t         vDec;

  logic pixelCe;
  logic active;
  logic hsync;
  logic vsync;
  logic lineStart;
  logic frameSync;

  assign subWrap = (sub == SUB_LAST);

  // sub-slot divider; resync realigns to slot 0
  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      sub <= '0;
    end else if (iResync || subWrap) begin
      sub <= '0;
    end else begin
      sub <= sub + 1'b1;
    end
  end

  video_timing_axis #(
    .TOTAL  (H_TOTAL),
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .MARK   (SYNC_DELAY_H),
    .W      (HW)
  ) uHAxis (
    .iClk  (iClk),
    .iRstN (iRstN),
    .iClr  (iResync),
    .iEn   (subWrap),
    .oPos  (hPos),
    .oDec  (hDec)
  );

  video_timing_axis #(
    .TOTAL  (V_TOTAL),
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .MARK   (SYNC_DELAY_V),
    .W      (VW)
  ) uVAxis (
    .iClk  (iClk),
    .iRstN (iRstN),
    .iClr  (iResync),
    .iEn   (subWrap && hDec.wrap),
    .oPos  (vPos),
    .oDec  (vDec)
  );

  // decoded strobes, one cycle behind the counters
  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      pixelCe   <= 1'b0;
      active    <= 1'b0;
      hsync     <= ~HS_POL;
      vsync     <= ~VS_POL;
      lineStart <= 1'b0;
      frameSync <= 1'b0;
    end else begin
      pixelCe   <= subWrap;
      active    <= hDec.active && vDec.active;
      hsync     <= hDec.sync ? HS_POL : ~HS_POL;
      vsync     <= vDec.sync ? VS_POL : ~VS_POL;
      lineStart <= (sub == '0) && (hPos == '0);
      frameSync <= (sub == SUB_MARK) && hDec.mark
                   && vDec.mark;
    end
  end

`ifdef VIDEO_TIMING_LOCK_DETECT_EN
  localparam int LW = cw(LOCK_COUNT);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_COUNT);

  logic          frameLast;
  logic [LW-1:0] lockCnt;
  logic [LW-1:0] lockNext;
  logic          locked;

  assign frameLast = subWrap && hDec.wrap && vDec.wrap;

  // aligned resyncs count up; misaligned or missing ones restart
  always_comb begin
    lockNext = lockCnt;
    if (iResync) begin
      if (!frameLast) begin
        lockNext = '0;
      end else if (lockCnt != LOCK_MAX) begin
        lockNext = lockCnt + 1'b1;
      end
    end else if (frameLast) begin
      lockNext = '0;
    end
  end

  // lock counter and its registered indicator
  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      lockCnt <= '0;
      locked  <= 1'b0;
    end else begin
      lockCnt <= lockNext;
      locked  <= (lockNext == LOCK_MAX);
    end
  end

  assign vid.oLocked = locked;
`else
  logic unusedVWrap;
  assign unusedVWrap = vDec.wrap;
  assign vid.oLocked = 1'b0;
`endif

  assign vid.oPixelCe   = pixelCe;
  assign vid.oSub       = sub;
  assign vid.oHpixel    = hPos;
  assign vid.oVpixel    = vPos;
  assign vid.oHsync     = hsync;
  assign vid.oVsync     = vsync;
  assign vid.oActive    = active;
  assign vid.oLineStart = lineStart;
  assign vid.oFrameSync = frameSync;

endmodule

// File: tb/tb_video_timing_generator.sv
// Bench: two generators (PIXEL_DIV 2 and 1) against a raster-position model.
// Lock expectations follow VIDEO_TIMING_LOCK_DETECT_EN.
module tb_video_timing_generator;
  import video_timing_generator_pkg::*;

  localparam int LC = 4;

  typedef struct {
    int pd, ha, hfp, hs, ht;
    int va, vfp, vs, vt;
    int sds, sdh, sdv;
    bit hpol, vpol;
  } cfg_t;

  typedef struct {
    logic [7:0] sub, h, v, pce, hs, vs, act, ls, fs, lk;
  } exp_t;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic resync = 1'b0;

  int nChecks = 0;
  int nPass = 0;
  int nFail = 0;

  cfg_t cfg[2];
  int t[2] = '{0, 0};
  int pt[2] = '{0, 0};
  bit pv[2] = '{1'b0, 1'b0};
  int lk[2] = '{0, 0};
  bit lkExp[2] = '{1'b0, 1'b0};

  bit acc = 1'b0;
  int aAct, aHs, aVs, aFs, aLs, bPce, bVs, bFs;

  always #5 clk = ~clk;

  video_timing_generator_if #(
    .SW(cw(2)), .HW(cw(8)), .VW(cw(6))
  ) vidA ();

  video_timing_generator_if #(
    .SW(cw(1)), .HW(cw(8)), .VW(cw(6))
  ) vidB ();

  video_timing_generator #(
    .PIXEL_DIV(2), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2),
    .H_TOTAL(8), .V_ACTIVE(3), .V_FP(1), .V_SYNC(1),
    .V_TOTAL(6), .HS_POL(1'b1), .VS_POL(1'b1),
    .SYNC_DELAY_SUB(1), .SYNC_DELAY_H(2),
    .SYNC_DELAY_V(1), .LOCK_COUNT(LC)
  ) dutA (
    .iClk(clk), .iRstN(rstN), .iResync(resync),
    .vid(vidA)
  );

  video_timing_generator #(
    .PIXEL_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2),
    .H_TOTAL(8), .V_ACTIVE(3), .V_FP(1), .V_SYNC(1),
    .V_TOTAL(6), .HS_POL(1'b1), .VS_POL(1'b0),
    .SYNC_DELAY_SUB(0), .SYNC_DELAY_H(0),
    .SYNC_DELAY_V(0), .LOCK_COUNT(LC)
  ) dutB (
    .iClk(clk), .iRstN(rstN), .iResync(resync),
    .vid(vidB)
  );

  task automatic cmp(string tag, logic [7:0] obs,
                     logic [7:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic int period(int d);
    return cfg[d].pd * cfg[d].ht * cfg[d].vt;
  endfunction

  // expected outputs: counters from the current raster
  // position, strobes from the position one cycle earlier
  function automatic exp_t expOf(int d);
    exp_t e;
    cfg_t c;
    int s, h, v;
    c = cfg[d];
    e.sub = 8'(t[d] % c.pd);
    e.h = 8'((t[d] / c.pd) % c.ht);
    e.v = 8'(t[d] / (c.pd * c.ht));
    e.lk = 8'(lkExp[d]);
    if (!pv[d]) begin
      e.pce = 8'd0; e.act = 8'd0;
      e.ls = 8'd0; e.fs = 8'd0;
      e.hs = 8'(!c.hpol); e.vs = 8'(!c.vpol);
    end else begin
      s = pt[d] % c.pd;
      h = (pt[d] / c.pd) % c.ht;
      v = pt[d] / (c.pd * c.ht);
      e.pce = 8'(s == c.pd - 1);
      e.act = 8'(h < c.ha && v < c.va);
      e.hs = 8'((h >= c.ha + c.hfp &&
                 h < c.ha + c.hfp + c.hs) ?
                c.hpol : !c.hpol);
      e.vs = 8'((v >= c.va + c.vfp &&
                 v < c.va + c.vfp + c.vs) ?
                c.vpol : !c.vpol);
      e.ls = 8'(s == 0 && h == 0);
      e.fs = 8'(s == c.sds && h == c.sdh % c.ht &&
                v == c.sdv % c.vt);
    end
    return e;
  endfunction

  task automatic modelEdge(bit rst, bit rs);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        t[d] = 0; pv[d] = 1'b0; lk[d] = 0;
      end else begin
        bit last;
        last = (t[d] == period(d) - 1);
        if (rs) lk[d] = last ? ((lk[d] < LC) ? lk[d] + 1 : LC) : 0;
        else if (last) lk[d] = 0;
        pt[d] = t[d];
        pv[d] = 1'b1;
        t[d] = rs ? 0 : (t[d] + 1) % period(d);
      end
`ifdef VIDEO_TIMING_LOCK_DETECT_EN
      lkExp[d] = (lk[d] == LC);
`else
      lkExp[d] = 1'b0;
`endif
    end
  endtask

  task automatic checkAll();
    exp_t ea, eb;
    ea = expOf(0);
    eb = expOf(1);
    cmp("A.sub", 8'(vidA.oSub), ea.sub);
    cmp("A.h", 8'(vidA.oHpixel), ea.h);
    cmp("A.v", 8'(vidA.oVpixel), ea.v);
    cmp("A.pce", 8'(vidA.oPixelCe), ea.pce);
    cmp("A.act", 8'(vidA.oActive), ea.act);
    cmp("A.hs", 8'(vidA.oHsync), ea.hs);
    cmp("A.vs", 8'(vidA.oVsync), ea.vs);
    cmp("A.ls", 8'(vidA.oLineStart), ea.ls);
    cmp("A.fs", 8'(vidA.oFrameSync), ea.fs);
    cmp("A.lock", 8'(vidA.oLocked), ea.lk);
    cmp("B.sub", 8'(vidB.oSub), eb.sub);
    cmp("B.h", 8'(vidB.oHpixel), eb.h);
    cmp("B.v", 8'(vidB.oVpixel), eb.v);
    cmp("B.pce", 8'(vidB.oPixelCe), eb.pce);
    cmp("B.act", 8'(vidB.oActive), eb.act);
    cmp("B.hs", 8'(vidB.oHsync), eb.hs);
    cmp("B.vs", 8'(vidB.oVsync), eb.vs);
    cmp("B.ls", 8'(vidB.oLineStart), eb.ls);
    cmp("B.fs", 8'(vidB.oFrameSync), eb.fs);
    cmp("B.lock", 8'(vidB.oLocked), eb.lk);
  endtask

  task automatic step(bit rst, bit rs);
    rstN = !rst;
    resync = rs;
    @(posedge clk);
    modelEdge(rst, rs);
    #1;
    checkAll();
    if (acc) begin
      aAct += int'(vidA.oActive === 1'b1);
      aHs += int'(vidA.oHsync === 1'b1);
      aVs += int'(vidA.oVsync === 1'b1);
      aFs += int'(vidA.oFrameSync === 1'b1);
      aLs += int'(vidA.oLineStart === 1'b1);
      bPce += int'(vidB.oPixelCe === 1'b1);
      bVs += int'(vidB.oVsync === 1'b0);
      bFs += int'(vidB.oFrameSync === 1'b1);
    end
    rstN = 1'b1;
    resync = 1'b0;
  endtask

  task automatic goTo(int target);
    int n;
    n = 0;
    while (t[0] != target && n < 200) begin
      step(1'b0, 1'b0);
      n++;
    end
    if (t[0] != target) begin
      nChecks++;
      nFail++;
      $error("FAIL goTo observed=%0d expected=%0d",
             t[0], target);
    end
  endtask

  task automatic pulseAt(int target);
    goTo(target);
    step(1'b0, 1'b1);
  endtask

  initial begin
    bit lockOn;
`ifdef VIDEO_TIMING_LOCK_DETECT_EN
    lockOn = 1'b1;
`else
    lockOn = 1'b0;
`endif
    cfg[0] = '{pd: 2, ha: 4, hfp: 1, hs: 2, ht: 8,
               va: 3, vfp: 1, vs: 1, vt: 6,
               sds: 1, sdh: 2, sdv: 1,
               hpol: 1'b1, vpol: 1'b1};
    cfg[1] = '{pd: 1, ha: 4, hfp: 1, hs: 2, ht: 8,
               va: 3, vfp: 1, vs: 1, vt: 6,
               sds: 0, sdh: 0, sdv: 0,
               hpol: 1'b1, vpol: 1'b0};
    {aAct, aHs, aVs, aFs, aLs, bPce, bVs, bFs} = '0;

    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    cmp("rstHsync", 8'(vidA.oHsync), 8'd0);
    cmp("rstVsyncB", 8'(vidB.oVsync), 8'd1);

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    acc = 1'b1;
    for (int i = 0; i < 96; i++) step(1'b0, 1'b0);
    acc = 1'b0;
    cmp("aActive96", 8'(aAct), 8'd24);
    cmp("aHsync96", 8'(aHs), 8'd24);
    cmp("aVsync96", 8'(aVs), 8'd16);
    cmp("aFrameSync96", 8'(aFs), 8'd1);
    cmp("aLineStart96", 8'(aLs), 8'd6);
    cmp("bPixelCe96", 8'(bPce), 8'd96);
    cmp("bVsync96", 8'(bVs), 8'd16);
    cmp("bFrameSync96", 8'(bFs), 8'd2);

    pulseAt(38);
    cmp("resyncSub", 8'(vidA.oSub), 8'd0);
    cmp("resyncH", 8'(vidA.oHpixel), 8'd0);
    cmp("resyncV", 8'(vidA.oVpixel), 8'd0);
    step(1'b0, 1'b0);
    cmp("resyncLineStart", 8'(vidA.oLineStart), 8'd1);

    pulseAt(95);
    cmp("wrapResyncH", 8'(vidA.oHpixel), 8'd0);
    cmp("wrapResyncV", 8'(vidA.oVpixel), 8'd0);

    for (int i = 0; i < 300; i++)
      step(1'b0, $urandom_range(0, 39) == 0);

    goTo(37);
    step(1'b1, 1'b0);
    cmp("midRstH", 8'(vidA.oHpixel), 8'd0);
    cmp("midRstAct", 8'(vidA.oActive), 8'd0);
    cmp("midRstLs", 8'(vidA.oLineStart), 8'd0);
    step(1'b0, 1'b0);
    cmp("restartSub", 8'(vidA.oSub), 8'd1);

    for (int i = 0; i < 3; i++) pulseAt(95);
    cmp("lockAfter3", 8'(vidA.oLocked), 8'd0);
    pulseAt(95);
    cmp("lockAfter4", 8'(vidA.oLocked), 8'(lockOn));
    pulseAt(92);
    cmp("lockMisalign", 8'(vidA.oLocked), 8'd0);
    for (int i = 0; i < 4; i++) pulseAt(95);
    cmp("relock", 8'(vidA.oLocked), 8'(lockOn));
    goTo(95);
    step(1'b0, 1'b0);
    cmp("lockMissing", 8'(vidA.oLocked), 8'd0);
    cmp("lockB", 8'(vidB.oLocked), 8'd0);

    for (int i = 0; i < 20; i++) step(1'b0, 1'b0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/video_timing_generator.md
Name: video_timing_generator

Overview:
Parametrised raster timing generator that drives all video pipelines from one system clock.
- Divides iClk into pixel slots (PIXEL_DIV clocks per pixel) and maintains the horizontal and vertical position.
- Produces registered hsync, vsync, active, line-start and delayed frame-sync strobes.
- Accepts an external resync pulse, so several generators or a capture source can share frame phase.

Parameters:
PIXEL_DIV, 2, iClk cycles per pixel (>=1)
H_ACTIVE, 24, active pixels per line
H_FP, 2, horizontal front porch, pixels
H_SYNC, 4, hsync width, pixels
H_TOTAL, 32, pixels per line (>= H_ACTIVE+H_FP+H_SYNC)
V_ACTIVE, 16, active lines per frame
V_FP, 1, vertical front porch, lines
V_SYNC, 2, vsync width, lines
V_TOTAL, 24, lines per frame (>= V_ACTIVE+V_FP+V_SYNC)
HS_POL, 1, hsync asserted level
VS_POL, 1, vsync asserted level
SYNC_DELAY_SUB, 0, sub-slot of oFrameSync strobe (< PIXEL_DIV)
SYNC_DELAY_H, 0, pixel offset of oFrameSync after frame wrap
SYNC_DELAY_V, 0, line offset of oFrameSync after frame wrap
LOCK_COUNT, 4, consecutive aligned resyncs needed for lock

Ports:
iClk  in  1  system clock
iRstN  in  1  synchronous active-low reset
iResync  in  1  external frame-start pulse, one cycle
oPixelCe  out  1  pixel enable, high on last sub-slot of each pixel
oSub  out  CLOG2(PIXEL_DIV)+1  sub-slot counter
oHpixel  out  CLOG2(H_TOTAL)+1  horizontal position
oVpixel  out  CLOG2(V_TOTAL)+1  vertical position
oHsync  out  1  horizontal sync, polarity HS_POL
oVsync  out  1  vertical sync, polarity VS_POL
oActive  out  1  in active area
oLineStart  out  1  one-cycle strobe at start of line
oFrameSync  out  1  one-cycle strobe at delayed frame position
oLocked  out  1  external sync lock indicator

Behaviour:
- Reset: iRstN sampled low on a rising edge.
  - oSub, oHpixel, oVpixel = 0.
  - oPixelCe, oActive, oLineStart, oFrameSync, oLocked = 0.
  - oHsync = ~HS_POL; oVsync = ~VS_POL.
  - Reset has priority over everything, including mid-frame.
- Counters:
  - oSub increments each cycle and wraps at PIXEL_DIV-1.
  - On wrap, oHpixel increments and wraps at H_TOTAL-1.
  - On oHpixel wrap, oVpixel increments and wraps at V_TOTAL-1.
  - PIXEL_DIV=1: oSub is held at 0 and the pixel advances every cycle.
- Resync: iResync high loads oSub/oHpixel/oVpixel = 0 on the next edge, overriding any natural wrap in the same cycle.
- Decoded outputs: registered from the current counter values, so they lag the counters by exactly 1 cycle.
  - oPixelCe = (oSub == PIXEL_DIV-1).
  - oActive = H < H_ACTIVE && V < V_ACTIVE.
  - oHsync asserted for H in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - oVsync asserted for V in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], over whole lines.
  - oLineStart = (oSub==0 && H==0).
  - oFrameSync = (oSub==SYNC_DELAY_SUB && H==SYNC_DELAY_H%H_TOTAL && V==SYNC_DELAY_V%V_TOTAL).
  - Comparison constants are computed modulo totals.
- Width: counters sized CLOG2(total)+1 bits; no overflow beyond total-1 is reachable.
- Parameter violations (porch/sync sum > total, SYNC_DELAY_SUB >= PIXEL_DIV) are caught by elaboration-time checks that stop simulation.

Optional Feature:
VIDEO_TIMING_LOCK_DETECT_EN
- Defined: a lock counter of width CLOG2(LOCK_COUNT)+1 is added.
  - An iResync arriving when counters are at (PIXEL_DIV-1, H_TOTAL-1, V_TOTAL-1) counts as aligned and increments the counter, saturating at LOCK_COUNT.
  - Any misaligned iResync clears the counter and oLocked on the next edge.
  - A full frame wrap with no iResync also clears them.
  - oLocked = (lock counter == LOCK_COUNT), registered.
- Undefined: oLocked tied to 0 and no lock logic is synthesised; the port list is unchanged.

Decomposition:
- Shared include common.v provides the CLOG2 macro.
- Shared include video_timing_defs.v provides default timing constants (for example 640x480 and 1280x720 sets) and polarity defines.
- One natural sub-module: video_timing_axis, instanced twice (H and V).
  - Function: counter with wrap enable, active/porch/sync decode and pulse-window compare.
  - The top holds the sub-slot divider, resync, frame strobe and lock logic.

Test Plan:
Common configuration: PIXEL_DIV=2, H_ACTIVE=4, H_FP=1, H_SYNC=2, H_TOTAL=8, V_ACTIVE=3, V_FP=1, V_SYNC=1, V_TOTAL=6.
- Free run, reset released at cycle 0 -> frame period 96 cycles; oActive high 8 cycles per line on lines 0-2 (24 per frame); oHsync = HS_POL for 4 cycles per line while H is 5-6; oVsync = VS_POL for 16 cycles on line 4.
- PIXEL_DIV=1 -> oSub constantly 0, oPixelCe constantly 1, frame period 48 cycles.
- SYNC_DELAY_SUB=1, SYNC_DELAY_H=2, SYNC_DELAY_V=1 -> exactly one oFrameSync per 96 cycles, 1 cycle after the counters read (1,2,1).
- iResync at H=3, V=2 -> next cycle counters are (0,0,0); oLineStart 1 cycle later; asserting iResync on a natural wrap cycle gives identical counters.
- iRstN low for 1 cycle mid-line -> all outputs at reset values next cycle; counting restarts from 0.
- Lock detect (VIDEO_TIMING_LOCK_DETECT_EN) -> iResync every 96 cycles aligned with wrap gives oLocked=1 after the 4th pulse; one pulse offset by 3 cycles drops oLocked next cycle; a missing pulse drops it at the frame wrap.
